dma_controller: RTL

- DMA engine that moves a block of data from external_device into data memory without CPU involvement.
- The CPU services the device interrupt, then issues a command (base address, length).
- The block then:
  - arbitrates for the memory bus with a BR/BG handshake;
  - walks the device offsets;
  - writes each 4-word (64-bit) device entry to memory as one burst;
  - returns the bus and pulses dma_done.
- Sits between external_device (upstream, drives its offset and consumes its data) and the memory write port (downstream).

---
 rtl/dma_controller_pkg.sv | 34 +++
 rtl/dma_controller_if.sv | 34 +++
 rtl/dma_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA engine that copies external_device entries into data memory.
// Holds the bus widths, the device geometry and the controller state encoding.
package dma_defs;

    localparam int WORD_SIZE      = 16;
    localparam int DEVICE_BIT_LEN = 2;
    localparam int NUM_BLOCKS     = 3;
    localparam int DATA_W         = 4 * WORD_SIZE;

    localparam logic [DEVICE_BIT_LEN-1:0] IDLE_OFFSET = 2'b11;

    typedef logic [WORD_SIZE-1:0]      word_t;
    typedef logic [DATA_W-1:0]         entry_t;
    typedef logic [DEVICE_BIT_LEN-1:0] blk_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FETCH,
        WRITE,
        DONE
    } state_e;

    // Converts a word count to whole 4-word entries, capped at what the device holds.
    function automatic blk_t clamp_blocks(input word_t len);
        word_t quads;
        quads = len >> 2;
        if (quads > word_t'(NUM_BLOCKS)) begin
            return blk_t'(NUM_BLOCKS);
        end
        return blk_t'(quads);
    endfunction

endpackage

// File: rtl/dma_controller_if.sv
// Command, bus-arbitration, device and memory-write signals of the DMA engine.
// master is the DMA side; slave is the CPU / device / memory side.
interface dma_controller_if;
    import dma_defs::*;

    logic   cmd_valid;
    word_t  cmd_addr;
    word_t  cmd_length;

    logic   bg;
    logic   br;

    blk_t   dev_offset;
    entry_t dev_data;

    word_t  mem_addr;
    entry_t mem_wdata;
    logic   mem_we;
    logic   mem_ack;

    logic   busy;
    logic   dma_done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_length, bg, dev_data, mem_ack,
        output br, dev_offset, mem_addr, mem_wdata, mem_we, busy, dma_done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_length, bg, dev_data, mem_ack,
        input  br, dev_offset, mem_addr, mem_wdata, mem_we, busy, dma_done
    );

endinterface

// File: rtl/dma_controller.sv
// DMA engine: after a CPU command it requests the memory bus, then for each device entry
// fetches it (one cycle) and writes it as a 4-word burst, releasing the bus and pulsing dma_done.
module dma_controller
    import dma_defs::*;
(
    input  logic             clk,
    input  logic             reset_n,
    dma_controller_if.master bus
);

    state_e state_q, state_d;
    blk_t   blk_q, blk_d;
    blk_t   nblk_q, nblk_d;
    word_t  base_q, base_d;
    word_t  mem_addr_q, mem_addr_d;
    entry_t mem_wdata_q, mem_wdata_d;

    blk_t   cmd_nblk;
    blk_t   blk_next;
    word_t  blk_byte_off;

    assign cmd_nblk     = clamp_blocks(bus.cmd_length);
    assign blk_next     = blk_q + blk_t'(1);
    assign blk_byte_off = {{(WORD_SIZE - DEVICE_BIT_LEN - 2){1'b0}}, blk_q, 2'b00};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            nblk_q      <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            nblk_q      <= nblk_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // NOTE: every signal written here gets a hold value first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        nblk_d      = nblk_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    base_d  = bus.cmd_addr;
                    nblk_d  = cmd_nblk;
                    blk_d   = '0;
                    state_d = (cmd_nblk == '0) ? DONE : REQ;
                end
            end

            // bg is only looked at here, so a grant withdrawn mid-burst
            // simply parks the next block until the CPU gives the bus back.
            REQ: begin
                if (bus.bg) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                mem_wdata_d = bus.dev_data;
                mem_addr_d  = base_q + blk_byte_off;
                state_d     = WRITE;
            end

            WRITE: begin
                if (bus.mem_ack) begin
                    blk_d   = blk_next;
                    state_d = (blk_next == nblk_q) ? DONE : REQ;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.br         = (state_q == REQ) || (state_q == FETCH) || (state_q == WRITE);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.dma_done   = (state_q == DONE);
    assign bus.dev_offset = (state_q == FETCH) ? blk_q : IDLE_OFFSET;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    a_we_implies_br : assert property (
        @(posedge clk) disable iff (!reset_n) bus.mem_we |-> bus.br
    );

    a_burst_stable : assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_q == WRITE && !bus.mem_ack) |=> ($stable(mem_addr_q) && $stable(mem_wdata_q))
    );

    a_done_single : assert property (
        @(posedge clk) disable iff (!reset_n) bus.dma_done |=> !bus.dma_done
    );

    a_blk_in_range : assert property (
        @(posedge clk) disable iff (!reset_n) (state_q == WRITE) |-> (blk_q < nblk_q)
    );

endmodule
